// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stack_ctrl
// Description : Stack pointer and sequencing controller placed in front of a
//               single-port memstack. Accepts push/pop/peek/clear commands,
//               drives the memory write/address port, captures the
//               combinational read data, and tracks depth with full/empty
//               status and sticky overflow/underflow errors. The stack grows
//               upward and sp always points at the next free word.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_ctrl #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 1024,
  localparam int AW    = $clog2(NWORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             cmd_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [AW:0]      depth,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow,
  output logic             mem_we,
  output logic [AW-1:0]    mem_a,
  output logic [WIDTH-1:0] mem_din,
  input  logic [WIDTH-1:0] mem_dout
);

  // Command encodings
  localparam logic [1:0] c_OP_PUSH  = 2'b00;
  localparam logic [1:0] c_OP_POP   = 2'b01;
  localparam logic [1:0] c_OP_PEEK  = 2'b10;
  localparam logic [1:0] c_OP_CLEAR = 2'b11;

  // Depth value at which the stack is full, sized to the pointer width
  localparam logic [AW:0] c_NWORDS = (AW+1)'(NWORDS);
  localparam logic [AW:0] c_ONE    = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      sp_q, sp_d;
  logic [WIDTH-1:0] wbuf_q, wbuf_d;
  logic             is_pop_q, is_pop_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             w_accept;
  logic             w_full;
  logic             w_empty;
  logic [AW:0]      w_sp_dec;

  // Status decode and memory port drive derived from the current state
  always_comb begin
    w_full    = (sp_q == c_NWORDS);
    w_empty   = (sp_q == '0);
    w_sp_dec  = sp_q - c_ONE;
    cmd_ready = (state_q == ST_IDLE) && !reset;
    w_accept  = cmd_valid && cmd_ready;
    // A write in flight is discarded when reset arrives in the WRITE cycle
    mem_we    = (state_q == ST_WRITE) && !reset;
    mem_din   = wbuf_q;
    if (state_q == ST_READ) begin
      mem_a = w_sp_dec[AW-1:0];
    end else begin
      mem_a = sp_q[AW-1:0];
    end
  end

  // Next-state and register-update logic for the command sequencer
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    wbuf_d      = wbuf_q;
    is_pop_d    = is_pop_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            c_OP_PUSH: begin
              if (w_full) begin
                overflow_d = 1'b1;
              end else begin
                wbuf_d  = cmd_data;
                state_d = ST_WRITE;
              end
            end
            c_OP_POP, c_OP_PEEK: begin
              if (w_empty) begin
                underflow_d = 1'b1;
              end else begin
                is_pop_d = (cmd_op == c_OP_POP);
                state_d  = ST_READ;
              end
            end
            c_OP_CLEAR: begin
              sp_d        = '0;
              overflow_d  = 1'b0;
              underflow_d = 1'b0;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end
      end
      ST_WRITE: begin
        sp_d    = sp_q + c_ONE;
        state_d = ST_IDLE;
      end
      ST_READ: begin
        rsp_data_d  = mem_dout;
        rsp_valid_d = 1'b1;
        if (is_pop_q) begin
          sp_d = w_sp_dec;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset overrides every state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sp_q        <= '0;
      wbuf_q      <= '0;
      is_pop_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      wbuf_q      <= wbuf_d;
      is_pop_q    <= is_pop_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Registered outputs
  always_comb begin
    depth     = sp_q;
    full      = w_full;
    empty     = w_empty;
    overflow  = overflow_q;
    underflow = underflow_q;
    rsp_valid = rsp_valid_q;
    rsp_data  = rsp_data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_ctrl
// Description : Directed self-checking bench for stack_ctrl with a small
//               behavioural memstack (NWORDS=4, WIDTH=16) behind it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_ctrl;

  localparam int WIDTH  = 16;
  localparam int NWORDS = 4;
  localparam int AW     = 2;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_ready;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic [AW:0]      depth;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;
  logic             mem_we;
  logic [AW-1:0]    mem_a;
  logic [WIDTH-1:0] mem_din;
  logic [WIDTH-1:0] mem_dout;

  logic [WIDTH-1:0] mem [NWORDS];
  int               we_count;
  int               checks;
  int               failures;
  int               we_base;

  stack_ctrl #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .depth     (depth),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memstack: synchronous write, combinational read
  assign mem_dout = mem[mem_a];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a] <= mem_din;
      we_count   <= we_count + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command for exactly one edge, then drop cmd_valid
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    issue(2'b00, d);
    step();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    we_count  = 0;
    for (int i = 0; i < NWORDS; i++) mem[i] = '0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    step();
    step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    reset = 1'b0;
    #1;
    chk("rst_depth", depth, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_ready_after", cmd_ready, 1);

    // 1: push two, pop two
    issue(2'b00, 16'h1111);
    chk("t1_we", mem_we, 1);
    chk("t1_a", mem_a, 0);
    chk("t1_din", mem_din, 16'h1111);
    chk("t1_busy", cmd_ready, 0);
    chk("t1_depth_n1", depth, 0);
    step();
    chk("t1_depth1", depth, 1);
    chk("t1_ready", cmd_ready, 1);
    push(16'h2222);
    chk("t1_depth2", depth, 2);
    issue(2'b01, 16'h0);
    chk("t1_rd_a", mem_a, 1);
    chk("t1_rd_we", mem_we, 0);
    chk("t1_rv_early", rsp_valid, 0);
    step();
    chk("t1_rv1", rsp_valid, 1);
    chk("t1_rd1", rsp_data, 16'h2222);
    chk("t1_dep_pop1", depth, 1);
    issue(2'b01, 16'h0);
    step();
    chk("t1_rv2", rsp_valid, 1);
    chk("t1_rd2", rsp_data, 16'h1111);
    chk("t1_dep_pop2", depth, 0);
    chk("t1_empty", empty, 1);
    step();
    chk("t1_rv_pulse", rsp_valid, 0);
    chk("t1_rd_hold", rsp_data, 16'h1111);

    // 2: fill, overflow, pop top
    push(16'h0A01);
    push(16'h0A02);
    push(16'h0A03);
    push(16'h0A04);
    chk("t2_depth4", depth, 4);
    chk("t2_full", full, 1);
    issue(2'b00, 16'h5555);
    chk("t2_ovf", overflow, 1);
    chk("t2_ovf_we", mem_we, 0);
    chk("t2_ovf_ready", cmd_ready, 1);
    chk("t2_ovf_depth", depth, 4);
    issue(2'b01, 16'h0);
    step();
    chk("t2_pop_rd", rsp_data, 16'h0A04);
    chk("t2_pop_depth", depth, 3);
    chk("t2_not_full", full, 0);
    chk("t2_ovf_sticky", overflow, 1);
    issue(2'b11, 16'h0);
    chk("t2_clr_depth", depth, 0);
    chk("t2_clr_ovf", overflow, 0);

    // 3: underflow on empty
    issue(2'b01, 16'h0);
    chk("t3_unf_pop", underflow, 1);
    chk("t3_rv_pop", rsp_valid, 0);
    chk("t3_ready", cmd_ready, 1);
    issue(2'b10, 16'h0);
    chk("t3_rv_peek", rsp_valid, 0);
    step();
    chk("t3_rv_peek2", rsp_valid, 0);
    chk("t3_unf_sticky", underflow, 1);
    chk("t3_depth", depth, 0);
    issue(2'b11, 16'h0);
    chk("t3_clr_unf", underflow, 0);

    // 4: peek twice
    push(16'hABCD);
    issue(2'b10, 16'h0);
    step();
    chk("t4_rv1", rsp_valid, 1);
    chk("t4_rd1", rsp_data, 16'hABCD);
    chk("t4_dep1", depth, 1);
    issue(2'b10, 16'h0);
    step();
    chk("t4_rv2", rsp_valid, 1);
    chk("t4_rd2", rsp_data, 16'hABCD);
    chk("t4_dep2", depth, 1);

    // 5: back-to-back pushes with cmd_valid held
    we_base   = we_count;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    for (int i = 0; i < 3; i++) begin
      cmd_data = 16'h1000 + 16'(i);
      chk("t5_ready_hi", cmd_ready, 1);
      step();
      chk("t5_ready_lo", cmd_ready, 0);
      chk("t5_we", mem_we, 1);
      cmd_data = 16'hDEAD;
      step();
    end
    cmd_valid = 1'b0;
    chk("t5_ready_end", cmd_ready, 1);
    chk("t5_we_count", we_count - we_base, 3);
    chk("t5_depth", depth, 4);
    chk("t5_mem3", mem[3], 16'h1002);
    chk("t5_mem1", mem[1], 16'h1000);

    // 6: reset during the WRITE cycle
    issue(2'b11, 16'h0);
    issue(2'b00, 16'h7777);
    chk("t6_we_pre", mem_we, 1);
    reset = 1'b1;
    #1;
    chk("t6_we_gated", mem_we, 0);
    chk("t6_ready_rst", cmd_ready, 0);
    step();
    reset = 1'b0;
    #1;
    chk("t6_mem0", mem[0], 16'hABCD);
    chk("t6_depth", depth, 0);
    chk("t6_empty", empty, 1);
    chk("t6_ready", cmd_ready, 1);
    chk("t6_rsp_data", rsp_data, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_unf", underflow, 0);
    step();
    chk("t6_depth_hold", depth, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
